// File: rtl/wb_i2c_cmd_seq.sv
// ---------------------------------------------------------------------------
// wb_i2c_cmd_seq
//   Wishbone master that sits in front of the I2C master core's register
//   port. After reset it programs the prescaler and sets EN. It then turns
//   each one-byte register write/read request into the TXR/CR write and
//   SR-poll sequence of a full I2C transaction, and returns the data and a
//   status code.
//
// Ports
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_rw                0 = register write, 1 = register read
//   req_dev/reg/wdata     7-bit device address, register address, write byte
//   rsp_valid             one-cycle response pulse (no backpressure)
//   rsp_rdata, rsp_err    read byte; 00 ok, 01 I2C NACK, 10 Wishbone timeout
//   wb_*                  Wishbone master port to the I2C core
// ---------------------------------------------------------------------------
module wb_i2c_cmd_seq #(
  parameter logic [15:0] PRESCALE    = 16'd99,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] wb_addr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  // Core register map
  localparam logic [2:0] A_PRERLO = 3'd0;
  localparam logic [2:0] A_PRERHI = 3'd1;
  localparam logic [2:0] A_CTR    = 3'd2;
  localparam logic [2:0] A_TXR    = 3'd3;
  localparam logic [2:0] A_CR     = 3'd4;

  // CR command bytes
  localparam logic [7:0] CR_STA_WR     = 8'h90;
  localparam logic [7:0] CR_WR         = 8'h10;
  localparam logic [7:0] CR_STO_WR     = 8'h50;
  localparam logic [7:0] CR_RD_NAK_STO = 8'h68;
  localparam logic [7:0] CR_STO        = 8'h40;
  localparam logic [7:0] CTR_EN        = 8'h80;

  typedef enum logic [1:0] {SEQ_INIT, SEQ_WR, SEQ_RD, SEQ_NACK} seq_e;
  // S_GAP is the mandatory idle cycle before every access; S_ACC is an
  // access in flight (stb/cyc high).
  typedef enum logic [1:0] {S_GAP, S_ACC, S_IDLE, S_RSP} state_e;
  typedef enum logic [1:0] {OP_WR, OP_POLL, OP_RD, OP_END} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] addr;
    logic [7:0] data;
    logic       chk;   // poll result is checked for RxACK
  } op_t;

  function automatic op_t mk(kind_e k, logic [2:0] a, logic [7:0] d, logic c);
    op_t o;
    o.kind = k;
    o.addr = a;
    o.data = d;
    o.chk  = c;
    return o;
  endfunction

  // Micro-program: one Wishbone access per step. A POLL step repeats until
  // TIP clears; OP_END marks the end of the sequence.
  function automatic op_t op_at(seq_e s, logic [3:0] st, logic [6:0] dev,
                                logic [7:0] rg, logic [7:0] wd);
    op_t o;
    o = mk(OP_END, 3'd0, 8'h00, 1'b0);
    unique case (s)
      SEQ_INIT: begin
        case (st)
          4'd0: o = mk(OP_WR, A_PRERLO, PRESCALE[7:0], 1'b0);
          4'd1: o = mk(OP_WR, A_PRERHI, PRESCALE[15:8], 1'b0);
          4'd2: o = mk(OP_WR, A_CTR, CTR_EN, 1'b0);
          default: ;
        endcase
      end
      SEQ_WR, SEQ_RD: begin
        case (st)
          4'd0: o = mk(OP_WR, A_TXR, {dev, 1'b0}, 1'b0);
          4'd1: o = mk(OP_WR, A_CR, CR_STA_WR, 1'b0);
          4'd2: o = mk(OP_POLL, A_CR, 8'h00, 1'b1);
          4'd3: o = mk(OP_WR, A_TXR, rg, 1'b0);
          4'd4: o = mk(OP_WR, A_CR, CR_WR, 1'b0);
          4'd5: o = mk(OP_POLL, A_CR, 8'h00, 1'b1);
          default: begin
            if (s == SEQ_WR) begin
              case (st)
                4'd6: o = mk(OP_WR, A_TXR, wd, 1'b0);
                4'd7: o = mk(OP_WR, A_CR, CR_STO_WR, 1'b0);
                4'd8: o = mk(OP_POLL, A_CR, 8'h00, 1'b1);
                default: ;
              endcase
            end else begin
              case (st)
                4'd6:  o = mk(OP_WR, A_TXR, {dev, 1'b1}, 1'b0);
                4'd7:  o = mk(OP_WR, A_CR, CR_STA_WR, 1'b0);  // repeated start
                4'd8:  o = mk(OP_POLL, A_CR, 8'h00, 1'b1);
                4'd9:  o = mk(OP_WR, A_CR, CR_RD_NAK_STO, 1'b0);
                4'd10: o = mk(OP_POLL, A_CR, 8'h00, 1'b0);  // master NACKs its own read
                4'd11: o = mk(OP_RD, A_TXR, 8'h00, 1'b0);
                default: ;
              endcase
            end
          end
        endcase
      end
      SEQ_NACK: begin
        case (st)
          4'd0: o = mk(OP_WR, A_CR, CR_STO, 1'b0);
          4'd1: o = mk(OP_POLL, A_CR, 8'h00, 1'b0);
          default: ;
        endcase
      end
    endcase
    return o;
  endfunction

  state_e        state_q, state_d;
  seq_e          seq_q, seq_d;
  logic [3:0]    step_q, step_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [1:0]    err_q, err_d;

  logic          wb_stb_q, wb_stb_d;
  logic          wb_we_q, wb_we_d;
  logic [2:0]    wb_addr_q, wb_addr_d;
  logic [7:0]    wb_dat_q, wb_dat_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;

  op_t           cur_op;
  op_t           acc_op;

  assign cur_op = op_at(seq_q, step_q, dev_q, reg_q, wdata_q);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_GAP;
      seq_q       <= SEQ_INIT;
      step_q      <= '0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_dat_q    <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      step_q      <= step_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_dat_q    <= wb_dat_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    seq_e       seq_nx;
    logic [3:0] step_nx;
    state_d = state_q;
    seq_d   = seq_q;
    step_d  = step_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    tmo_d   = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    seq_nx  = seq_q;
    step_nx = step_q + 4'd1;

    unique case (state_q)
      S_GAP: state_d = S_ACC;

      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = S_ACC;
          seq_d   = req_rw ? SEQ_RD : SEQ_WR;
          step_d  = '0;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = '0;
        end
      end

      S_ACC: begin
        if (wb_ack_i) begin
          if (cur_op.kind == OP_POLL) begin
            if (wb_dat_i[1]) begin
              step_nx = step_q;                  // TIP still set: poll again
            end else if (cur_op.chk && wb_dat_i[7]) begin
              seq_nx  = SEQ_NACK;                // slave did not ACK
              step_nx = '0;
            end
          end
          if (cur_op.kind == OP_RD) rdata_d = wb_dat_i;
          seq_d  = seq_nx;
          step_d = step_nx;
          if (op_at(seq_nx, step_nx, dev_q, reg_q, wdata_q).kind == OP_END) begin
            if (seq_q == SEQ_INIT) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_RSP;
              err_d   = (seq_nx == SEQ_NACK) ? 2'b01 : 2'b00;
            end
          end else begin
            state_d = S_GAP;
          end
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          // Abandon the transaction without STO; during INIT simply start over.
          step_d = '0;
          if (seq_q == SEQ_INIT) begin
            state_d = S_GAP;
          end else begin
            state_d = S_RSP;
            err_d   = 2'b10;
            rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_RSP: state_d = S_IDLE;
    endcase
  end

  // Output logic: every Wishbone output is registered, derived from the
  // state and step being entered so that all of them change together.
  assign acc_op = op_at(seq_d, step_d, dev_d, reg_d, wdata_d);

  always_comb begin
    wb_stb_d    = (state_d == S_ACC);
    wb_we_d     = wb_stb_d && (acc_op.kind == OP_WR);
    wb_addr_d   = wb_stb_d ? acc_op.addr : 3'd0;
    wb_dat_d    = wb_we_d ? acc_op.data : 8'h00;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
  end

  assign wb_stb_o  = wb_stb_q;
  assign wb_cyc_o  = wb_stb_q;
  assign wb_we_o   = wb_we_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_dat_o  = wb_dat_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_wb_i2c_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_wb_i2c_cmd_seq
//   Directed bench for wb_i2c_cmd_seq. A small I2C-core register model acks
//   each access one cycle after strobe, logs every write as {addr,data},
//   reports TIP for a few polls after each CR write and can force RxACK or
//   withhold ack. A bus monitor watches handshake rules throughout.
// ---------------------------------------------------------------------------
module tb_wb_i2c_cmd_seq;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  always #5 clk = ~clk;

  wb_i2c_cmd_seq #(.PRESCALE(16'd99), .ACK_TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- core register model ----------------
  bit          withhold = 1'b0;
  int          tip_len = 2;
  int          nack_on_cr = -1;
  logic [7:0]  rxr = 8'h00;
  int          tip_cnt = 0;
  logic        rxack = 1'b0;
  logic        ack = 1'b0;
  int          cr_cnt = 0;
  int          polls = 0;
  int          rd_cnt = 0;
  logic [10:0] wlog[$];

  assign wb_ack_i = ack;
  assign wb_dat_i = (wb_addr_o == 3'd4) ? {rxack, 5'b0, (tip_cnt != 0), 1'b0} :
                    (wb_addr_o == 3'd3) ? rxr : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      ack     <= 1'b0;
      tip_cnt <= 0;
      rxack   <= 1'b0;
    end else begin
      ack <= wb_stb_o && wb_cyc_o && !ack && !withhold;
      if (wb_stb_o && ack) begin
        if (wb_we_o) begin
          wlog.push_back({wb_addr_o, wb_dat_o});
          if (wb_addr_o == 3'd4) begin
            tip_cnt <= tip_len;
            rxack   <= (cr_cnt == nack_on_cr);
            cr_cnt  <= cr_cnt + 1;
          end
        end else begin
          if (wb_addr_o == 3'd4) begin
            polls <= polls + 1;
            if (tip_cnt != 0) tip_cnt <= tip_cnt - 1;
          end
          if (wb_addr_o == 3'd3) rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  int         cyc_n = 0, viol = 0, rsp_cnt = 0, run = 0, to_run = 0;
  int         last_ack_cyc = 0, rsp_gap = 0;
  logic       p_stb = 1'b0, p_ack = 1'b0, p_rst = 1'b1, p_we = 1'b0;
  logic [2:0] p_addr = '0;
  logic [7:0] p_dat = '0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb_stb_o !== wb_cyc_o) viol <= viol + 1;
    // strobe may only drop after ack, after a full timeout, or due to reset
    if (p_stb && !wb_stb_o && !p_ack && !p_rst) begin
      to_run <= run;
      if (run != TMO) viol <= viol + 1;
    end
    if (p_stb && p_ack && wb_stb_o) viol <= viol + 1;
    if (p_stb && wb_stb_o && !p_ack && !p_rst &&
        {p_we, p_addr, p_dat} != {wb_we_o, wb_addr_o, wb_dat_o}) viol <= viol + 1;
    run <= wb_stb_o ? run + 1 : 0;
    if (wb_stb_o && wb_ack_i) last_ack_cyc <= cyc_n;
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_gap <= cyc_n - last_ack_cyc;
    end
    p_stb  <= wb_stb_o;
    p_ack  <= wb_ack_i;
    p_rst  <= rst;
    p_we   <= wb_we_o;
    p_addr <= wb_addr_o;
    p_dat  <= wb_dat_o;
  end

  // ---------------- helpers ----------------
  logic [10:0] exp_q[$];
  int          log_base = 0;

  task automatic check_log(input string tag);
    chk({tag, "_len"}, wlog.size() - log_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && log_base + i < wlog.size(); i++)
      chk(tag, {21'd0, wlog[log_base + i]}, {21'd0, exp_q[i]});
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, req_ready, 1);
  endtask

  task automatic do_req(input string tag, input logic rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [7:0] wd,
                        output logic [7:0] rd, output logic [1:0] er);
    int n = 0;
    rd = '0;
    er = '0;
    wait_ready(tag);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_rdy_drop"}, req_ready, 0);
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  logic [7:0] rd;
  logic [1:0] er;
  int         pb, rb, n;

  initial begin
    // 1: reset state and INIT programming
    repeat (3) @(negedge clk);
    chk("rst_outs", {6'd0, wb_stb_o, wb_cyc_o, wb_we_o, wb_addr_o, wb_dat_o,
                     req_ready, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    log_base = wlog.size();
    rst = 1'b0;
    wait_ready("init");
    exp_q = {11'h063, 11'h100, 11'h280};
    check_log("init");

    // 2: register write, all ACK
    log_base = wlog.size(); pb = polls;
    do_req("wr", 1'b0, 7'h50, 8'h10, 8'hA5, rd, er);
    exp_q = {11'h3A0, 11'h490, 11'h310, 11'h410, 11'h3A5, 11'h450};
    check_log("wr");
    chk("wr_err", er, 0);
    chk("wr_rdata", rd, 0);
    chk("wr_polls", polls - pb, 9);
    chk("wr_rsp_lat", rsp_gap, 1);

    // 3: register read
    rxr = 8'h3C;
    log_base = wlog.size(); pb = polls; rb = rd_cnt;
    do_req("rd", 1'b1, 7'h50, 8'h10, 8'h00, rd, er);
    exp_q = {11'h3A0, 11'h490, 11'h310, 11'h410, 11'h3A1, 11'h490, 11'h468};
    check_log("rd");
    chk("rd_data", rd, 8'h3C);
    chk("rd_err", er, 0);
    chk("rd_polls", polls - pb, 12);
    chk("rd_rxr_reads", rd_cnt - rb, 1);
    chk("rd_rsp_lat", rsp_gap, 1);

    // 4a: NACK on address phase of a write
    log_base = wlog.size(); nack_on_cr = cr_cnt;
    do_req("nak_a", 1'b0, 7'h50, 8'h10, 8'h77, rd, er);
    exp_q = {11'h3A0, 11'h490, 11'h440};
    check_log("nak_a");
    chk("nak_a_err", er, 2'b01);
    chk("nak_a_rdata", rd, 0);
    chk("nak_a_rsp_lat", rsp_gap, 1);

    // 4b: NACK on register phase of a read
    log_base = wlog.size(); nack_on_cr = cr_cnt + 1;
    do_req("nak_r", 1'b1, 7'h33, 8'h04, 8'h00, rd, er);
    exp_q = {11'h366, 11'h490, 11'h304, 11'h410, 11'h440};
    check_log("nak_r");
    chk("nak_r_err", er, 2'b01);
    chk("nak_r_rdata", rd, 0);
    nack_on_cr = -1;

    // 5: ack withheld on the first TXR write
    withhold = 1'b1;
    log_base = wlog.size();
    do_req("tmo", 1'b1, 7'h50, 8'h10, 8'h00, rd, er);
    exp_q = {};
    check_log("tmo");
    chk("tmo_err", er, 2'b10);
    chk("tmo_rdata", rd, 0);
    chk("tmo_stb_cycles", to_run, TMO);
    withhold = 1'b0;

    // 6: reset while polling SR, with a request presented during reset
    tip_len = 40;
    wait_ready("rst6");
    req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h01; req_wdata = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(wb_stb_o && !wb_we_o && wb_addr_o == 3'd4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst6_polling", {wb_stb_o, wb_we_o, wb_addr_o}, {1'b1, 1'b0, 3'd4});
    rb = rsp_cnt;
    rst = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst6_stb_drop", {wb_stb_o, wb_cyc_o}, 2'b00);
    @(negedge clk);
    log_base = wlog.size();
    rst = 1'b0;
    req_valid = 1'b0;
    tip_len = 2;
    wait_ready("rerun");
    exp_q = {11'h063, 11'h100, 11'h280};
    check_log("rerun");
    chk("rst6_no_rsp", rsp_cnt - rb, 0);

    // recovery write after reset
    log_base = wlog.size();
    do_req("post", 1'b0, 7'h21, 8'h05, 8'h5A, rd, er);
    exp_q = {11'h342, 11'h490, 11'h305, 11'h410, 11'h35A, 11'h450};
    check_log("post");
    chk("post_err", er, 0);

    // 7: handshake rules over the whole run
    chk("bus_protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
